// File: rtl/raised_symbol_slicer.sv
// Symbol recovery after the matched filter: amplitude frame detect, fixed-phase
// decision per symbol, sign slicing, and a one-deep handshaked output buffer.
module raised_symbol_slicer #(
  parameter int WIDTH         = 16,
  parameter int SPS           = 8,
  parameter int SAMPLE_OFFSET = 4,
  parameter int THRESH        = 2048,
  parameter int FRAME_BITS    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] datain,
  input  logic                    readready,
  output logic                    dataout,
  output logic                    writeready,
  input  logic                    waitwrite,
  output logic                    complete,
  output logic                    overflow,
  output logic                    busy
);

  localparam int PW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(SPS - 1);
  localparam logic [PW-1:0] PHASE_DEC  = PW'(SAMPLE_OFFSET);
  localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);
  localparam logic signed [WIDTH:0] THRESH_X = (WIDTH+1)'(THRESH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [BW-1:0]   bitcnt_q, bitcnt_d;
  logic            dataout_q, dataout_d;
  logic            wr_q, wr_d;
  logic            complete_q, complete_d;
  logic            overflow_q, overflow_d;
  logic            busy_q, busy_d;

  logic signed [WIDTH:0] ext_s, mag_s;
  logic [PW-1:0]         phase_inc_s;
  logic                  detect_s, decide_s, bit_s;

  // Magnitude is taken one bit wider so -2^(WIDTH-1) cannot wrap.
  always_comb begin
    ext_s       = {datain[WIDTH-1], datain};
    mag_s       = ext_s[WIDTH] ? -ext_s : ext_s;
    detect_s    = readready && (mag_s >= THRESH_X);
    bit_s       = ~datain[WIDTH-1];
    phase_inc_s = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
    decide_s    = (state_q == ST_TRACK) && readready && (phase_inc_s == PHASE_DEC);
  end

  // Next-state and output-buffer logic.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bitcnt_d   = bitcnt_q;
    dataout_d  = dataout_q;
    wr_d       = wr_q;
    overflow_d = overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (detect_s) begin
          state_d  = ST_TRACK;
          phase_d  = '0;
          bitcnt_d = '0;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_TRACK: begin
        if (readready) begin
          phase_d = phase_inc_s;
          if (decide_s) begin
            bitcnt_d = bitcnt_q + BW'(1);
            if (bitcnt_q == BIT_LAST) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_TRACK;
            end
          end else begin
            state_d = ST_TRACK;
          end
        end else begin
          state_d = ST_TRACK;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A decision always wins the buffer; losing an unaccepted bit is sticky.
    if (decide_s) begin
      dataout_d  = bit_s;
      wr_d       = 1'b1;
      overflow_d = overflow_q | (wr_q & ~waitwrite);
    end else if (wr_q && waitwrite) begin
      wr_d = 1'b0;
    end else begin
      wr_d = wr_q;
    end

    complete_d = (state_d == ST_DONE);
    busy_d     = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      bitcnt_q   <= '0;
      dataout_q  <= 1'b0;
      wr_q       <= 1'b0;
      complete_q <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bitcnt_q   <= bitcnt_d;
      dataout_q  <= dataout_d;
      wr_q       <= wr_d;
      complete_q <= complete_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
    end
  end

  assign dataout    = dataout_q;
  assign writeready = wr_q;
  assign complete   = complete_q;
  assign overflow   = overflow_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_raised_symbol_slicer.sv
// Self-checking bench for raised_symbol_slicer: directed scenarios with random
// amplitudes and handshakes, checked every cycle against a sample-counting model.
module tb_raised_symbol_slicer;

  localparam int SPS = 8;
  localparam int OFF = 4;
  localparam int THR = 2048;
  localparam int FB  = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] datain;
  logic               readready, waitwrite;
  logic               dataout, writeready, complete, overflow, busy;

  int passed = 0;
  int total  = 0;

  // Reference model: samples counted since detect, bits counted per frame.
  int   m_mode;   // 0 idle, 1 tracking, 2 frame done
  int   m_n, m_bits;
  logic m_wr, m_do, m_ov, m_cmp, m_busy;
  logic rx[$];

  raised_symbol_slicer #(
    .WIDTH(16), .SPS(SPS), .SAMPLE_OFFSET(OFF), .THRESH(THR), .FRAME_BITS(FB)
  ) dut (
    .clk(clk), .reset(reset), .datain(datain), .readready(readready),
    .dataout(dataout), .writeready(writeready), .waitwrite(waitwrite),
    .complete(complete), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic model_clear();
    m_mode = 0; m_n = 0; m_bits = 0;
    m_wr = 1'b0; m_do = 1'b0; m_ov = 1'b0; m_cmp = 1'b0; m_busy = 1'b0;
  endtask

  task automatic model_update(input logic signed [15:0] d, input logic rr, input logic ww);
    int   v;
    logic dec, b;
    dec = 1'b0;
    b   = 1'b0;
    v   = d;
    if (m_mode == 0) begin
      if (v < 0) v = -v;
      if (rr && v >= THR) begin
        m_mode = 1; m_n = 0; m_bits = 0;
      end
    end else if (m_mode == 1) begin
      if (rr) begin
        m_n++;
        if (m_n % SPS == OFF) begin
          dec = 1'b1;
          b   = (d >= 0);
          m_bits++;
          if (m_bits == FB) m_mode = 2;
        end
      end
    end else begin
      m_mode = 0;
    end
    if (dec) begin
      if (m_wr && !ww) m_ov = 1'b1;
      m_wr = 1'b1;
      m_do = b;
    end else if (m_wr && ww) begin
      m_wr = 1'b0;
    end
    m_cmp  = (m_mode == 2);
    m_busy = (m_mode != 0);
  endtask

  task automatic check_outputs();
    chk("dataout", dataout, m_do);
    chk("writeready", writeready, m_wr);
    chk("complete", complete, m_cmp);
    chk("overflow", overflow, m_ov);
    chk("busy", busy, m_busy);
  endtask

  task automatic step(input logic signed [15:0] d, input logic rr, input logic ww);
    datain = d; readready = rr; waitwrite = ww;
    if (writeready === 1'b1 && ww) rx.push_back(dataout);
    @(posedge clk); #1;
    model_update(d, rr, ww);
    check_outputs();
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_dataout", dataout, 1'b0);
    chk("rst_writeready", writeready, 1'b0);
    chk("rst_complete", complete, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_busy", busy, 1'b0);
    model_clear();
    rx.delete();
    @(posedge clk); #3 reset = 1'b1;
  endtask

  function automatic logic signed [15:0] rand_big();
    int a;
    a = int'($urandom_range(THR, 32767));
    return ($urandom_range(0, 1) != 0) ? 16'(a) : 16'(-a);
  endfunction

  function automatic logic signed [15:0] rand_small();
    int a;
    a = int'($urandom_range(0, THR - 1));
    return ($urandom_range(0, 1) != 0) ? 16'(a) : 16'(-a);
  endfunction

  // ww modes: 0 always ready, 1 never, 2 random, 3 only on decision samples
  function automatic logic ww_of(input int mode, input int j);
    case (mode)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return ($urandom_range(0, 1) != 0);
      default: return (j == OFF);
    endcase
  endfunction

  task automatic send_sym(input logic b, input int nsamp, input int mode,
                          input bit gaps, input int amp);
    int a;
    for (int j = 0; j < nsamp; j++) begin
      if (gaps && $urandom_range(0, 2) == 0)
        step(rand_big(), 1'b0, (mode == 3) ? 1'b0 : ww_of(mode, -1));
      a = (amp != 0) ? amp : int'($urandom_range(THR, 32767));
      step(b ? 16'(a) : 16'(-a), 1'b1, ww_of(mode, j));
    end
  endtask

  task automatic send_frame(input logic [7:0] bits, input int mode_first3,
                            input int mode_rest, input bit gaps, input int amp);
    for (int i = 0; i < FB; i++)
      send_sym(bits[7-i], (i == FB - 1) ? OFF + 1 : SPS,
               (i < 3) ? mode_first3 : mode_rest, gaps, amp);
    repeat (4) step(rand_small(), 1'b1, 1'b1);
  endtask

  task automatic check_rx(input logic [7:0] bits, input int first);
    chk("rx_count", rx.size(), FB - first);
    for (int k = 0; k < rx.size() && k < FB - first; k++)
      chk("rx_bit", rx[k], bits[7-first-k]);
    rx.delete();
  endtask

  initial begin
    logic [7:0] fr;
    reset = 1'b0; datain = '0; readready = 1'b0; waitwrite = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 check_outputs();
    @(posedge clk); #3 reset = 1'b1;

    // Sub-threshold samples never start a frame
    for (int i = 0; i < 16; i++) step((i % 2 == 0) ? 16'sd1000 : -16'sd1000, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(rand_small(), 1'b1, 1'b0);
    step(16'sd2047, 1'b1, 1'b1);
    step(-16'sd2047, 1'b1, 1'b1);
    step(16'sd9000, 1'b0, 1'b1);
    step(-16'sd2048, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) step(rand_small(), 1'b1, 1'b1);
    do_reset();

    // Nominal frame, always ready
    send_frame(8'b10110010, 0, 0, 1'b0, 8000);
    check_rx(8'b10110010, 0);

    // Backpressure through three decisions, then ready
    send_frame(8'b10110010, 1, 0, 1'b0, 8000);
    check_rx(8'b10110010, 2);
    do_reset();

    // Ready only on decision cycles
    send_frame(8'b10110010, 3, 3, 1'b0, 8000);
    check_rx(8'b10110010, 0);

    // Full-scale negative detect, zero decision sample, readready gaps
    do_reset();
    fr = 8'($urandom) | 8'h80;
    step(16'sh8000, 1'b1, 1'b1);
    for (int j = 1; j < OFF; j++) begin
      if ($urandom_range(0, 1) != 0) step(rand_big(), 1'b0, 1'b1);
      step(rand_big(), 1'b1, 1'b1);
    end
    step(16'sd0, 1'b1, 1'b1);
    for (int j = OFF + 1; j < SPS; j++) step(rand_big(), 1'b1, 1'b1);
    for (int i = 1; i < FB; i++)
      send_sym(fr[7-i], (i == FB - 1) ? OFF + 1 : SPS, 0, 1'b1, 0);
    repeat (4) step(rand_small(), 1'b1, 1'b1);
    check_rx(fr, 0);

    // Abort mid-frame, then decode a fresh frame
    fr = 8'($urandom);
    for (int i = 0; i < 3; i++) send_sym(fr[7-i], SPS, 0, 1'b0, 0);
    do_reset();
    fr = 8'($urandom);
    send_frame(fr, 0, 0, 1'b0, 0);
    check_rx(fr, 0);

    // Random frames with random handshake and gaps
    for (int r = 0; r < 4; r++) begin
      send_frame(8'($urandom), 2, 2, 1'b1, 0);
      rx.delete();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
